hd_program_loader: RTL and testbench

//  Sits directly downstream of the BIOS HD scanner. Captures each {start,end} file

---
 rtl/hd_program_loader.sv | 273 +++++++++++++++++++++++++++
 tb/tb_hd_program_loader.sv | 316 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/hd_program_loader.sv
// hd_program_loader: captures HD file records from the BIOS scanner into a
// program table and copies a selected program body from HD into imem.
//
// Build option: define LOADER_CHECKSUM_EN to enable the XOR checksum of
// copied words; when undefined, checksum is tied to zero.
//
// Ports:
//   clk, reset        clock, asynchronous active-high reset
//   save_page, page   record strobe; page = {start_pc, end_pc}
//   bios_active       loads are refused while the BIOS scan runs
//   load_req/pid      copy request (sampled in IDLE only)
//   hd_rd/addr/data   HD read port; data valid the cycle after hd_rd
//   imem_we/addr/wd   instruction-memory write port (body offset address)
//   load_busy         copy in progress (RD/WR)
//   load_done/err     1-cycle completion / rejection pulses
//   bad_page          1-cycle pulse on a rejected record
//   prog_count        valid table entries; table_full when at depth
//   checksum          XOR of the words written by the last copy
module hd_program_loader #(
  parameter int MAX_PROGS = 16,
  parameter int PID_W     = 4,
  parameter int IMEM_AW   = 10
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               save_page,
  input  logic [31:0]        page,
  input  logic               bios_active,
  input  logic               load_req,
  input  logic [PID_W-1:0]   load_pid,
  output logic               hd_rd,
  output logic [15:0]        hd_addr,
  input  logic [31:0]        hd_data,
  output logic               imem_we,
  output logic [IMEM_AW-1:0] imem_addr,
  output logic [31:0]        imem_wdata,
  output logic               load_busy,
  output logic               load_done,
  output logic               load_err,
  output logic               bad_page,
  output logic [PID_W:0]     prog_count,
  output logic               table_full,
  output logic [31:0]        checksum
);

  localparam logic [PID_W:0] CNT_MAX =
    (PID_W+1)'(MAX_PROGS);
  localparam logic [16:0] MAX_LEN =
    17'(2**IMEM_AW);

  typedef enum logic [1:0] {
    S_IDLE,
    S_RD,
    S_WR,
    S_DONE
  } state_t;

  state_t state, state_n;

  logic [31:0]        tbl [MAX_PROGS];
  logic [PID_W:0]     count_q;

  logic [15:0]        cur_q, cur_n;
  logic [15:0]        last_q, last_n;
  logic [IMEM_AW-1:0] ptr_q, ptr_n;

  // ---------------------------------------------------------------
  // Record capture
  // ---------------------------------------------------------------
  // Widened to 17 bits so start = 0xFFFF cannot wrap start+1 to 0.
  logic [16:0] rec_start1;
  logic [16:0] rec_end;
  logic [16:0] rec_len;
  logic        rec_short;
  logic        rec_long;
  logic        rec_bad;
  logic        full;
  logic        rec_store;

  assign rec_start1 = {1'b0, page[31:16]} + 17'd1;
  assign rec_end    = {1'b0, page[15:0]};
  assign rec_len    = rec_end - rec_start1;
  assign rec_short  = (rec_end <= rec_start1);
  assign rec_long   = (rec_len > MAX_LEN);
  assign rec_bad    = rec_short | rec_long;
  assign full       = (count_q == CNT_MAX);
  assign rec_store  = save_page & ~rec_bad & ~full;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < MAX_PROGS; i++)
        tbl[i] <= '0;
      count_q  <= '0;
      bad_page <= 1'b0;
    end else begin
      bad_page <= save_page & rec_bad;
      if (rec_store) begin
        tbl[count_q[PID_W-1:0]] <= page;
        count_q <= count_q + 1'b1;
      end
    end
  end

  assign prog_count = count_q;
  assign table_full = full;

  // ---------------------------------------------------------------
  // Load request decode
  // ---------------------------------------------------------------
  // Uses the pre-increment count: a record saved in the same cycle
  // becomes loadable only from the next cycle.
  logic        pid_ok;
  logic        req_ok;
  logic        accept;
  logic        reject;
  logic [31:0] sel;

  assign pid_ok = ({1'b0, load_pid} < count_q);
  assign req_ok = pid_ok & ~bios_active;
  assign sel    = tbl[load_pid];
  assign accept = (state == S_IDLE) & load_req & req_ok;
  assign reject = (state == S_IDLE) & load_req & ~req_ok;

  // ---------------------------------------------------------------
  // FSM: state and copy pointers
  // ---------------------------------------------------------------
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state  <= S_IDLE;
      cur_q  <= '0;
      last_q <= '0;
      ptr_q  <= '0;
    end else begin
      state  <= state_n;
      cur_q  <= cur_n;
      last_q <= last_n;
      ptr_q  <= ptr_n;
    end
  end

  // ---------------------------------------------------------------
  // FSM: next state
  // ---------------------------------------------------------------
  // last holds end-1, the HD address of the final body word.
  always_comb begin
    state_n = state;
    cur_n   = cur_q;
    last_n  = last_q;
    ptr_n   = ptr_q;
    unique case (state)
      S_IDLE: begin
        if (accept) begin
          state_n = S_RD;
          cur_n   = sel[31:16] + 16'd1;
          last_n  = sel[15:0] - 16'd1;
          ptr_n   = '0;
        end
      end
      S_RD: begin
        state_n = S_WR;
      end
      S_WR: begin
        cur_n = cur_q + 16'd1;
        ptr_n = ptr_q + IMEM_AW'(1);
        if (cur_q == last_q)
          state_n = S_DONE;
        else
          state_n = S_RD;
      end
      S_DONE: begin
        state_n = S_IDLE;
      end
      default: begin
        state_n = S_IDLE;
      end
    endcase
  end

  // ---------------------------------------------------------------
  // FSM: output decode
  // ---------------------------------------------------------------
  // The read strobe is launched from the next state so it overlaps
  // RD; the HD word then returns during WR and is written at the
  // end of WR, so write outputs trail WR by one cycle.
  logic               hd_rd_d;
  logic [15:0]        hd_addr_d;
  logic               imem_we_d;
  logic [IMEM_AW-1:0] imem_addr_d;
  logic [31:0]        imem_wdata_d;
  logic               busy_d;
  logic               done_d;
  logic               err_d;

  always_comb begin
    hd_rd_d      = 1'b0;
    hd_addr_d    = '0;
    imem_we_d    = 1'b0;
    imem_addr_d  = '0;
    imem_wdata_d = '0;
    busy_d       = 1'b0;
    done_d       = 1'b0;
    err_d        = reject;
    unique case (state_n)
      S_RD: begin
        hd_rd_d   = 1'b1;
        hd_addr_d = cur_n;
        busy_d    = 1'b1;
      end
      S_WR: begin
        busy_d = 1'b1;
      end
      default: begin
      end
    endcase
    unique case (state)
      S_WR: begin
        imem_we_d    = 1'b1;
        imem_addr_d  = ptr_q;
        imem_wdata_d = hd_data;
      end
      S_DONE: begin
        done_d = 1'b1;
      end
      default: begin
      end
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      hd_rd      <= 1'b0;
      hd_addr    <= '0;
      imem_we    <= 1'b0;
      imem_addr  <= '0;
      imem_wdata <= '0;
      load_busy  <= 1'b0;
      load_done  <= 1'b0;
      load_err   <= 1'b0;
    end else begin
      hd_rd      <= hd_rd_d;
      hd_addr    <= hd_addr_d;
      imem_we    <= imem_we_d;
      imem_addr  <= imem_addr_d;
      imem_wdata <= imem_wdata_d;
      load_busy  <= busy_d;
      load_done  <= done_d;
      load_err   <= err_d;
    end
  end

  // ---------------------------------------------------------------
  // Checksum
  // ---------------------------------------------------------------
`ifdef LOADER_CHECKSUM_EN
  // Accumulates the same word that is being registered into
  // imem_wdata, so it is final on the edge of the last write.
  logic [31:0] csum_q;

  always_ff @(posedge clk or posedge reset) begin
    if (reset)
      csum_q <= '0;
    else if (accept)
      csum_q <= '0;
    else if (state == S_WR)
      csum_q <= csum_q ^ hd_data;
  end

  assign checksum = csum_q;
`else
  assign checksum = '0;
`endif

endmodule

// File: tb/tb_hd_program_loader.sv
// tb_hd_program_loader: directed + randomized checks of hd_program_loader
// against a record-queue / HD-memory reference model.
`timescale 1ns/1ps
module tb_hd_program_loader;

  localparam int MAXP = 16;
  localparam int PW   = 4;
  localparam int AW   = 10;

  logic          clk = 1'b0;
  logic          reset = 1'b1;
  logic          save_page = 1'b0;
  logic [31:0]   page = '0;
  logic          bios_active = 1'b0;
  logic          load_req = 1'b0;
  logic [PW-1:0] load_pid = '0;
  logic          hd_rd;
  logic [15:0]   hd_addr;
  logic [31:0]   hd_data = '0;
  logic          imem_we;
  logic [AW-1:0] imem_addr;
  logic [31:0]   imem_wdata;
  logic          load_busy;
  logic          load_done;
  logic          load_err;
  logic          bad_page;
  logic [PW:0]   prog_count;
  logic          table_full;
  logic [31:0]   checksum;

  hd_program_loader #(
    .MAX_PROGS(MAXP),
    .PID_W(PW),
    .IMEM_AW(AW)
  ) dut (
    .clk(clk),
    .reset(reset),
    .save_page(save_page),
    .page(page),
    .bios_active(bios_active),
    .load_req(load_req),
    .load_pid(load_pid),
    .hd_rd(hd_rd),
    .hd_addr(hd_addr),
    .hd_data(hd_data),
    .imem_we(imem_we),
    .imem_addr(imem_addr),
    .imem_wdata(imem_wdata),
    .load_busy(load_busy),
    .load_done(load_done),
    .load_err(load_err),
    .bad_page(bad_page),
    .prog_count(prog_count),
    .table_full(table_full),
    .checksum(checksum)
  );

  always #5 clk = ~clk;

  // HD model: word returned the cycle after the read strobe,
  // junk otherwise so a mistimed capture shows up.
  logic [31:0] hd_mem [65536];
  always @(posedge clk)
    hd_data <= hd_rd ? hd_mem[hd_addr] : $urandom;

  int checks = 0;
  int errors = 0;
  logic [31:0] model_tbl [$];

  task automatic chk(input string tag,
                     input logic [63:0] obs,
                     input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h",
             tag, obs, exp);
    end
  endtask

  function automatic bit rec_valid(input logic [31:0] p);
    int s;
    int e;
    s = int'(p[31:16]);
    e = int'(p[15:0]);
    return (e > s + 1) && (e - s - 1 <= (1 << AW));
  endfunction

  function automatic logic [31:0] rand_rec();
    int s;
    int e;
    s = $urandom_range(0, 60000);
    e = s + $urandom_range(1, 12) + 1;
    return {s[15:0], e[15:0]};
  endfunction

  function automatic logic [31:0] exp_csum(input int s,
                                           input int len);
    logic [31:0] x;
    x = '0;
`ifdef LOADER_CHECKSUM_EN
    for (int i = 0; i < len; i++)
      x ^= hd_mem[s + 1 + i];
`endif
    return x;
  endfunction

  task automatic all_zero(input string tag);
    chk({tag, "_hd_rd"}, hd_rd, 0);
    chk({tag, "_hd_addr"}, hd_addr, 0);
    chk({tag, "_imem_we"}, imem_we, 0);
    chk({tag, "_imem_addr"}, imem_addr, 0);
    chk({tag, "_imem_wdata"}, imem_wdata, 0);
    chk({tag, "_busy"}, load_busy, 0);
    chk({tag, "_done"}, load_done, 0);
    chk({tag, "_err"}, load_err, 0);
    chk({tag, "_bad"}, bad_page, 0);
    chk({tag, "_count"}, prog_count, 0);
    chk({tag, "_full"}, table_full, 0);
    chk({tag, "_csum"}, checksum, 0);
  endtask

  task automatic save_rec(input logic [31:0] p);
    bit ok;
    ok = rec_valid(p);
    @(negedge clk);
    save_page = 1'b1;
    page = p;
    @(negedge clk);
    save_page = 1'b0;
    if (ok && model_tbl.size() < MAXP)
      model_tbl.push_back(p);
    chk("bad_page", bad_page, !ok);
    chk("prog_count", prog_count, model_tbl.size());
    chk("table_full", table_full, model_tbl.size() == MAXP);
  endtask

  task automatic req_err(input int pid);
    @(negedge clk);
    load_req = 1'b1;
    load_pid = pid[PW-1:0];
    @(negedge clk);
    load_req = 1'b0;
    chk("load_err", load_err, 1);
    chk("err_no_rd", hd_rd, 0);
    chk("err_no_busy", load_busy, 0);
    @(negedge clk);
    chk("err_pulse", load_err, 0);
    chk("err_idle", hd_rd, 0);
  endtask

  // Copy of entry pid, optionally with a concurrent record save
  // and a load request poked in while busy.
  task automatic do_load(input int pid, input bit poke,
                         input bit with_save,
                         input logic [31:0] sp);
    logic [31:0] rec;
    int s, e, len, nrd, nwr, done_at, errs;
    rec = model_tbl[pid];
    s = int'(rec[31:16]);
    e = int'(rec[15:0]);
    len = e - s - 1;
    nrd = 0;
    nwr = 0;
    done_at = -1;
    errs = 0;
    @(negedge clk);
    load_req = 1'b1;
    load_pid = pid[PW-1:0];
    if (with_save) begin
      save_page = 1'b1;
      page = sp;
    end
    @(negedge clk);
    load_req = 1'b0;
    save_page = 1'b0;
    if (with_save) begin
      if (rec_valid(sp) && model_tbl.size() < MAXP)
        model_tbl.push_back(sp);
      chk("sim_count", prog_count, model_tbl.size());
    end
    chk("busy_on_accept", load_busy, 1);
    for (int k = 0; k < 2*len + 8 && done_at < 0; k++) begin
      if (hd_rd) begin
        chk("hd_addr", hd_addr, s + 1 + nrd);
        nrd++;
      end
      if (imem_we) begin
        chk("imem_addr", imem_addr, nwr % (1 << AW));
        chk("imem_wdata", imem_wdata, hd_mem[s + 1 + nwr]);
        nwr++;
      end
      if (load_err) errs++;
      if (load_done) done_at = k;
      load_req = (poke && k == 2);
      if (load_req) load_pid = PW'($urandom);
      if (done_at < 0) @(negedge clk);
    end
    load_req = 1'b0;
    chk("rd_count", nrd, len);
    chk("wr_count", nwr, len);
    chk("done_latency", done_at, 2*len + 1);
    chk("no_err_in_copy", errs, 0);
    chk("busy_at_done", load_busy, 0);
    chk("checksum", checksum, exp_csum(s, len));
    @(negedge clk);
    chk("done_pulse", load_done, 0);
    chk("idle_no_rd", hd_rd, 0);
  endtask

  initial begin
    logic [31:0] p;
    int n;
    int seen;
    for (int a = 0; a < 65536; a++)
      hd_mem[a] = $urandom;
    hd_mem[6] = 32'h0000_000A;
    hd_mem[7] = 32'h0000_0005;
    hd_mem[8] = 32'h0000_00F0;

    repeat (2) @(negedge clk);
    all_zero("reset");
    reset = 1'b0;

    // rejected records
    save_rec(32'h0009_0005);
    save_rec(32'h0004_0005);
    save_rec(32'h0005_0006);
    save_rec(32'h0000_0402);
    save_rec(32'hFFFF_FFFF);

    // nothing loadable yet
    req_err(0);

    // basic copy, body 0xA,0x5,0xF0
    save_rec(32'h0005_0009);
    do_load(0, 0, 0, '0);
`ifdef LOADER_CHECKSUM_EN
    chk("checksum_ff", checksum, 32'hFF);
`else
    chk("checksum_ff", checksum, 32'h0);
`endif

    // maximum body length, with a request poked while busy
    save_rec(32'h0100_0501);
    do_load(1, 1, 0, '0);

    bios_active = 1'b1;
    req_err(0);
    bios_active = 1'b0;
    req_err(model_tbl.size());

    // save and load of the new index in the same cycle
    p = rand_rec();
    n = model_tbl.size();
    @(negedge clk);
    save_page = 1'b1;
    page = p;
    load_req = 1'b1;
    load_pid = n[PW-1:0];
    @(negedge clk);
    save_page = 1'b0;
    load_req = 1'b0;
    model_tbl.push_back(p);
    chk("sim_err", load_err, 1);
    chk("sim_bad", bad_page, 0);
    chk("sim_count", prog_count, model_tbl.size());
    chk("sim_no_rd", hd_rd, 0);
    do_load(n, 0, 0, '0);

    // save alongside an accepted load
    do_load(0, 0, 1, rand_rec());

    // reset in the middle of a copy
    @(negedge clk);
    load_req = 1'b1;
    load_pid = '0;
    @(negedge clk);
    load_req = 1'b0;
    repeat (3) @(negedge clk);
    #2 reset = 1'b1;
    #1 all_zero("mid_reset");
    @(negedge clk);
    reset = 1'b0;
    model_tbl.delete();
    seen = 0;
    repeat (10) begin
      @(negedge clk);
      if (hd_rd || load_busy || load_done || load_err)
        seen++;
    end
    chk("quiet_after_reset", seen, 0);

    // random fill up to full, then one dropped record
    while (model_tbl.size() < MAXP) begin
      if ($urandom_range(0, 3) == 0)
        save_rec($urandom);
      else
        save_rec(rand_rec());
    end
    save_rec(rand_rec());
    chk("drop_count", prog_count, MAXP);
    chk("drop_full", table_full, 1);

    do_load(15, 0, 0, '0);
    bios_active = 1'b1;
    req_err($urandom_range(0, 15));
    bios_active = 1'b0;
    repeat (6)
      do_load($urandom_range(0, 15), 1'($urandom), 0, '0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
